// File: rtl/sdram_write.sv
// sdram_write: full-page burst write sequencer (ACTIVE, tRCD, WRITE, B_TERM, tWR, PRECHARGE, tRP).
// Define SDRAM_WR_DQM_EN to add the wr_dqm byte-mask output.
module sdram_write #(
    parameter int TRCD_CLK = 2,
    parameter int TWR_CLK  = 2,
    parameter int TRP_CLK  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        wr_en,
    input  logic [23:0] wr_addr,
    input  logic [9:0]  wr_burst_len,
    input  logic [15:0] wr_data,
    output logic        wr_fifo_rd_en,
    output logic        wr_end,
    output logic [3:0]  write_cmd,
    output logic [1:0]  write_ba,
    output logic [12:0] write_addr,
    output logic        wr_sdram_en,
    output logic [15:0] wr_sdram_data
`ifdef SDRAM_WR_DQM_EN
    ,
    output logic [1:0]  wr_dqm
`endif
);
    localparam logic [3:0] CMD_NOP    = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE = 4'b0011;
    localparam logic [3:0] CMD_WRITE  = 4'b0100;
    localparam logic [3:0] CMD_BTERM  = 4'b0110;
    localparam logic [3:0] CMD_PRE    = 4'b0010;
    localparam logic [9:0] TRCD_LAST  = 10'(TRCD_CLK - 1);
    localparam logic [9:0] TWR_LAST   = 10'(TWR_CLK - 1);
    localparam logic [9:0] TRP_LAST   = 10'(TRP_CLK - 2);

    typedef enum logic [3:0] {
        WR_IDLE, WR_ACTIVE, WR_TRCD, WR_WRITE, WR_DATA,
        WR_BTERM, WR_TWR, WR_PRE, WR_TRP, WR_END
    } state_t;

    state_t      state, state_n;
    logic [9:0]  cnt, len, len_eff;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    logic        accept;

    assign accept  = (state == WR_IDLE) && wr_en && init_end;
    assign len_eff = (wr_burst_len == 10'd0) ? 10'd1 :
                     (wr_burst_len > 10'd512) ? 10'd512 : wr_burst_len;

    always_comb begin
        state_n = state;
        case (state)
            WR_IDLE:   state_n = accept ? WR_ACTIVE : WR_IDLE;
            WR_ACTIVE: state_n = WR_TRCD;
            WR_TRCD:   state_n = (cnt >= TRCD_LAST) ? WR_WRITE : WR_TRCD;
            WR_WRITE:  state_n = (len == 10'd1) ? WR_BTERM : WR_DATA;
            WR_DATA:   state_n = (cnt + 10'd2 >= len) ? WR_BTERM : WR_DATA;
            WR_BTERM:  state_n = WR_TWR;
            WR_TWR:    state_n = (cnt >= TWR_LAST) ? WR_PRE : WR_TWR;
            WR_PRE:    state_n = (TRP_CLK > 1) ? WR_TRP : WR_END;
            WR_TRP:    state_n = (cnt >= TRP_LAST) ? WR_END : WR_TRP;
            default:   state_n = WR_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= WR_IDLE;
            cnt   <= '0;
            bank  <= '0;
            row   <= '0;
            col   <= '0;
            len   <= 10'd1;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 10'd1;
            if (accept) begin
                bank <= wr_addr[23:22];
                row  <= wr_addr[21:9];
                col  <= wr_addr[8:0];
                len  <= len_eff;
            end
        end
    end

    // FIFO has one cycle of read latency, so reads lead the DQ window by one cycle
    assign wr_fifo_rd_en = ((state == WR_TRCD) && (cnt >= TRCD_LAST)) ||
                           ((state == WR_WRITE) && (len != 10'd1)) ||
                           ((state == WR_DATA) && (cnt + 10'd2 < len));
    assign wr_sdram_en   = (state == WR_WRITE) || (state == WR_DATA);
    assign wr_sdram_data = wr_sdram_en ? wr_data : 16'h0;
    assign wr_end        = (state == WR_END);
    assign write_cmd     = (state == WR_ACTIVE) ? CMD_ACTIVE :
                           (state == WR_WRITE)  ? CMD_WRITE  :
                           (state == WR_BTERM)  ? CMD_BTERM  :
                           (state == WR_PRE)    ? CMD_PRE    : CMD_NOP;
    assign write_ba      = ((state == WR_ACTIVE) || (state == WR_WRITE)) ? bank : 2'b11;
    assign write_addr    = (state == WR_ACTIVE) ? row :
                           (state == WR_WRITE)  ? {4'b0000, col} : 13'h1fff;
`ifdef SDRAM_WR_DQM_EN
    assign wr_dqm        = wr_sdram_en ? 2'b00 : 2'b11;
`endif
endmodule

// File: tb/tb_sdram_write.sv
// tb_sdram_write: directed self-checking bench for sdram_write with a 1-cycle-latency FIFO model.
module tb_sdram_write;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        wr_en = 1'b0;
    logic [23:0] wr_addr = '0;
    logic [9:0]  wr_burst_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_fifo_rd_en, wr_end, wr_sdram_en;
    logic [3:0]  write_cmd;
    logic [1:0]  write_ba;
    logic [12:0] write_addr;
    logic [15:0] wr_sdram_data;
`ifdef SDRAM_WR_DQM_EN
    logic [1:0]  wr_dqm;
`endif
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;

    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, WRC = 4'b0100, BT = 4'b0110, PRE = 4'b0010;

    sdram_write dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_burst_len(wr_burst_len), .wr_data(wr_data),
        .wr_fifo_rd_en(wr_fifo_rd_en), .wr_end(wr_end), .write_cmd(write_cmd),
        .write_ba(write_ba), .write_addr(write_addr), .wr_sdram_en(wr_sdram_en),
        .wr_sdram_data(wr_sdram_data)
`ifdef SDRAM_WR_DQM_EN
        , .wr_dqm(wr_dqm)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (wr_fifo_rd_en) begin
            wr_data <= 16'hA000 + rd_cnt[15:0];
            rd_cnt  <= rd_cnt + 1;
        end
    end

    task automatic test_reset;
        #1;
        checks++; if (write_cmd !== NOP) begin errors++; $display("FAIL reset_cmd got %b want %b", write_cmd, NOP); end
        checks++; if (write_ba !== 2'b11) begin errors++; $display("FAIL reset_ba got %b want 11", write_ba); end
        checks++; if (write_addr !== 13'h1fff) begin errors++; $display("FAIL reset_addr got %h want 1fff", write_addr); end
        checks++; if (wr_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", wr_fifo_rd_en); end
        checks++; if (wr_sdram_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", wr_sdram_en); end
        checks++; if (wr_end !== 1'b0) begin errors++; $display("FAIL reset_end got %b want 0", wr_end); end
        checks++; if (wr_sdram_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0", wr_sdram_data); end
`ifdef SDRAM_WR_DQM_EN
        checks++; if (wr_dqm !== 2'b11) begin errors++; $display("FAIL reset_dqm got %b want 11", wr_dqm); end
`endif
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_gating;
        int s;
        s = rd_cnt;
        init_end = 1'b0;
        wr_en = 1'b1;
        wr_addr = 24'h400A05;
        wr_burst_len = 10'd4;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            checks++; if (write_cmd !== NOP) begin errors++; $display("FAIL gate_cmd cyc %0d got %b want %b", i, write_cmd, NOP); end
        end
        checks++; if (rd_cnt !== s) begin errors++; $display("FAIL gate_reads got %0d want %0d", rd_cnt - s, 0); end
        wr_en = 1'b0;
        init_end = 1'b1;
        @(negedge sys_clk);
    endtask

    // Drives one request at cycle c and checks every output cycle by cycle against the
    // expected schedule (TRCD=TWR=TRP=2): ACTIVE c+1, WRITE c+4, B_TERM c+4+L, PRE c+7+L, end c+9+L.
    task automatic run_burst(input logic [23:0] a, input logic [9:0] bl, input bit disturb, input bit do_reset);
        int L, s, bi;
        logic [3:0] ecmd;
        logic [1:0] eba;
        logic [12:0] eaddr;
        logic een, erd, eend;
        logic [15:0] edata;
        bi = int'(bl);
        L = (bi == 0) ? 1 : (bi > 512) ? 512 : bi;
        s = rd_cnt;
        wr_addr = a;
        wr_burst_len = bl;
        init_end = 1'b1;
        wr_en = 1'b1;
        for (int k = 1; k <= L + 10; k++) begin
            @(negedge sys_clk);
            wr_en = disturb && (k >= 2) && (k <= L + 5) && (k % 2 == 1);
            if (disturb && k == 2) begin
                wr_addr = 24'hFFFFFF;
                wr_burst_len = 10'd3;
            end
            if (do_reset && k == 6) begin
                sys_rst_n = 1'b0;
                #1;
                checks++; if (write_cmd !== NOP) begin errors++; $display("FAIL rst_mid_cmd got %b want %b", write_cmd, NOP); end
                checks++; if (wr_sdram_en !== 1'b0) begin errors++; $display("FAIL rst_mid_en got %b want 0", wr_sdram_en); end
                checks++; if (wr_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rd got %b want 0", wr_fifo_rd_en); end
                for (int j = 0; j < 3; j++) begin
                    @(negedge sys_clk);
                    checks++; if (wr_end !== 1'b0) begin errors++; $display("FAIL rst_mid_end got %b want 0", wr_end); end
                end
                checks++; if (rd_cnt - s !== 3) begin errors++; $display("FAIL rst_mid_reads got %0d want 3", rd_cnt - s); end
                sys_rst_n = 1'b1;
                @(negedge sys_clk);
                return;
            end
            ecmd  = (k == 1) ? ACT : (k == 4) ? WRC : (k == 4 + L) ? BT : (k == 7 + L) ? PRE : NOP;
            eba   = (k == 1 || k == 4) ? a[23:22] : 2'b11;
            eaddr = (k == 1) ? a[21:9] : (k == 4) ? {4'b0000, a[8:0]} : 13'h1fff;
            een   = (k >= 4) && (k < 4 + L);
            erd   = (k >= 3) && (k < 3 + L);
            eend  = (k == L + 9);
            edata = een ? 16'hA000 + 16'(s + k - 4) : 16'h0;
            checks++; if (write_cmd !== ecmd) begin errors++; $display("FAIL cmd L=%0d k=%0d got %b want %b", L, k, write_cmd, ecmd); end
            checks++; if (write_ba !== eba) begin errors++; $display("FAIL ba L=%0d k=%0d got %b want %b", L, k, write_ba, eba); end
            checks++; if (write_addr !== eaddr) begin errors++; $display("FAIL addr L=%0d k=%0d got %h want %h", L, k, write_addr, eaddr); end
            checks++; if (wr_sdram_en !== een) begin errors++; $display("FAIL dq_en L=%0d k=%0d got %b want %b", L, k, wr_sdram_en, een); end
            checks++; if (wr_fifo_rd_en !== erd) begin errors++; $display("FAIL rd_en L=%0d k=%0d got %b want %b", L, k, wr_fifo_rd_en, erd); end
            checks++; if (wr_end !== eend) begin errors++; $display("FAIL wr_end L=%0d k=%0d got %b want %b", L, k, wr_end, eend); end
            checks++; if (wr_sdram_data !== edata) begin errors++; $display("FAIL dq L=%0d k=%0d got %h want %h", L, k, wr_sdram_data, edata); end
`ifdef SDRAM_WR_DQM_EN
            checks++; if (wr_dqm !== (een ? 2'b00 : 2'b11)) begin errors++; $display("FAIL dqm L=%0d k=%0d got %b want %b", L, k, wr_dqm, een ? 2'b00 : 2'b11); end
`endif
        end
        checks++; if (rd_cnt - s !== L) begin errors++; $display("FAIL reads L=%0d got %0d want %0d", L, rd_cnt - s, L); end
    endtask

    task automatic test_basic;
        run_burst(24'h400A05, 10'd4, 1'b0, 1'b0);
    endtask

    task automatic test_len_bounds;
        run_burst({2'b10, 13'h1234, 9'h0FF}, 10'd1, 1'b0, 1'b0);
        run_burst({2'b00, 13'h0001, 9'h100}, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic test_full_page;
        run_burst({2'b10, 13'h0ABC, 9'h1F0}, 10'd512, 1'b0, 1'b0);
        run_burst({2'b01, 13'h1FFE, 9'h003}, 10'h3FF, 1'b0, 1'b0);
    endtask

    task automatic test_disturb;
        run_burst({2'b11, 13'h0777, 9'h1FE}, 10'd6, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset;
        run_burst({2'b01, 13'h0042, 9'h010}, 10'd8, 1'b0, 1'b1);
        run_burst({2'b01, 13'h0042, 9'h010}, 10'd8, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_gating;
        test_basic;
        test_len_bounds;
        test_full_page;
        test_disturb;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
